// File: rtl/task_icd_pkg.sv
// Shared task-interface constants, response codes and the bank command word builder.
// Define BANK_CMD_PARITY_EN to place odd parity in command word bit 27.
package task_icd_pkg;

   localparam int unsigned HEADER_BYTES = 8;

   localparam logic [31:0] TASK_VALID      = 32'h0000_0001;
   localparam logic [31:0] HEADER_INVALID  = 32'h0000_0002;
   localparam logic [31:0] PAYLOAD_INVALID = 32'h0000_0003;
   localparam logic [31:0] EXE_ERROR       = 32'h0000_0004;

   localparam logic [3:0]  BANK_CMD_ID     = 4'b0000;

   function automatic logic [31:0] mk_bank_cmd(input logic [3:0]  id,
                                               input logic [15:0] v,
                                               input logic [7:0]  b);
      logic [31:0] w;
      w = {id, 4'b0000, v, b};
`ifdef BANK_CMD_PARITY_EN
      // bit 27 is still zero here, so ~^w makes the whole word odd
      w[27] = ~^w;
`endif
      return w;
   endfunction

endpackage

// File: rtl/bank_cmd_len_decode.sv
// Combinational task length decoder: len (header included) -> pair count and legality.
module bank_cmd_len_decode #(
   parameter int unsigned NUM_CMDS  = 4,
   parameter int unsigned HDR_BYTES = 8,
   parameter int unsigned NW        = 5
) (
   input  logic [31:0]   i_len,
   output logic          o_ok,
   output logic [NW-1:0] o_n
);

   logic [31:0] w_d;
   logic [31:0] w_n;

   // i_len > HDR_BYTES is checked explicitly so a short len cannot wrap into a legal count
   assign w_d  = i_len - HDR_BYTES;
   assign w_n  = {3'b000, w_d[31:3]};
   assign o_ok = (i_len > HDR_BYTES) && (w_d[2:0] == 3'b000) &&
                 (w_n >= 32'd1) && (w_n <= NUM_CMDS);
   assign o_n  = w_n[NW-1:0];

endmodule

// File: rtl/bank_cmd_multi.sv
// Multi-pair bank command task handler: validates a task, streams one word per pair.
// Define BANK_CMD_PARITY_EN to enable odd parity in word bit 27.
module bank_cmd_multi
   import task_icd_pkg::*;
#(
   parameter int unsigned NUM_CMDS    = 4,
   parameter int unsigned BANK_BITS   = 4,
   parameter int unsigned VAL_BITS    = 8,
   parameter logic [3:0]  CMD_ID      = BANK_CMD_ID,
   parameter int unsigned MAX_TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        task_valid,
   input  logic [31:0] len_bytes,
   input  logic [31:0] bank [NUM_CMDS],
   input  logic [31:0] val  [NUM_CMDS],
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp,
   output logic [4:0]  cmds_sent,
   input  logic        aso_cmd_ready,
   output logic        aso_cmd_valid,
   output logic [31:0] aso_cmd_data
);

   localparam int IW = $clog2(NUM_CMDS + 1);
   localparam int TW = (MAX_TIMEOUT > 0) ? $clog2(MAX_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, VALIDATE_LEN, VALIDATE_PAYLOAD, SRC} state_t;

   state_t              r_state, w_state_nxt;
   logic [IW-1:0]       r_idx, w_idx_nxt, w_idx_inc;
   logic [IW-1:0]       r_limit, w_limit_nxt;
   logic [TW-1:0]       r_tmo, w_tmo_nxt;
   logic [4:0]          r_cmds, w_cmds_nxt;
   logic                r_valid, w_valid_nxt;
   logic [31:0]         r_data, w_data_nxt;
   logic                r_resp_valid, w_resp_valid_nxt;
   logic [31:0]         r_resp, w_resp_nxt;
   logic                r_busy;
   logic [31:0]         r_len;
   logic [7:0]          r_bank [NUM_CMDS];
   logic [15:0]         r_val  [NUM_CMDS];
   logic [NUM_CMDS-1:0] r_pair_ok;
   logic                w_load, w_hs, w_sel_ok, w_len_ok;
   logic [IW-1:0]       w_len_n;
   logic [7:0]          w_nb;
   logic [15:0]         w_nv;

   bank_cmd_len_decode #(
      .NUM_CMDS  (NUM_CMDS),
      .HDR_BYTES (HEADER_BYTES),
      .NW        (IW)
   ) u_len_dec (
      .i_len (r_len),
      .o_ok  (w_len_ok),
      .o_n   (w_len_n)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_limit_nxt      = r_limit;
      w_tmo_nxt        = r_tmo;
      w_cmds_nxt       = r_cmds;
      w_valid_nxt      = r_valid;
      w_resp_valid_nxt = 1'b0;
      w_resp_nxt       = r_resp;
      w_load           = 1'b0;
      w_hs             = r_valid & aso_cmd_ready;
      w_idx_inc        = r_idx + 1'b1;
      w_sel_ok         = 1'b0;
      for (int i = 0; i < NUM_CMDS; i++)
         if (IW'(i) == r_idx) w_sel_ok = r_pair_ok[i];

      case (r_state)
         IDLE: begin
            if (task_valid) begin
               w_load      = 1'b1;
               w_state_nxt = VALIDATE_LEN;
            end
         end
         VALIDATE_LEN: begin
            if (w_len_ok) begin
               w_limit_nxt = w_len_n;
               w_idx_nxt   = '0;
               w_state_nxt = VALIDATE_PAYLOAD;
            end else begin
               w_resp_valid_nxt = 1'b1;
               w_resp_nxt       = HEADER_INVALID;
               w_state_nxt      = IDLE;
            end
         end
         VALIDATE_PAYLOAD: begin
            if (r_idx == r_limit) begin
               w_idx_nxt   = '0;
               w_tmo_nxt   = '0;
               w_cmds_nxt  = '0;
               w_valid_nxt = 1'b1;
               w_state_nxt = SRC;
            end else if (!w_sel_ok) begin
               w_resp_valid_nxt = 1'b1;
               w_resp_nxt       = PAYLOAD_INVALID;
               w_state_nxt      = IDLE;
            end else begin
               w_idx_nxt = w_idx_inc;
            end
         end
         SRC: begin
            // handshake is tested first so it wins over a coincident timeout
            if (w_hs) begin
               w_idx_nxt  = w_idx_inc;
               w_cmds_nxt = r_cmds + 5'd1;
               w_tmo_nxt  = '0;
               if (w_idx_inc == r_limit) begin
                  w_valid_nxt      = 1'b0;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_nxt       = TASK_VALID;
                  w_state_nxt      = IDLE;
               end
            end else if (MAX_TIMEOUT != 0 && r_tmo == TW'(MAX_TIMEOUT)) begin
               w_valid_nxt      = 1'b0;
               w_resp_valid_nxt = 1'b1;
               w_resp_nxt       = EXE_ERROR;
               w_state_nxt      = IDLE;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // word for the pair the stream will present next cycle
      w_nb = 8'h00;
      w_nv = 16'h0000;
      for (int i = 0; i < NUM_CMDS; i++)
         if (IW'(i) == w_idx_nxt) begin
            w_nb = r_bank[i];
            w_nv = r_val[i];
         end
      w_data_nxt = mk_bank_cmd(CMD_ID, w_nv, w_nb);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_limit      <= '0;
         r_tmo        <= '0;
         r_cmds       <= '0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_resp_valid <= 1'b0;
         r_resp       <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_limit      <= w_limit_nxt;
         r_tmo        <= w_tmo_nxt;
         r_cmds       <= w_cmds_nxt;
         r_valid      <= w_valid_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp       <= w_resp_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         if (w_valid_nxt) r_data <= w_data_nxt;
      end
   end

   // pair legality is folded to one flag at capture so only the used field bits are kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_pair_ok <= '0;
         for (int i = 0; i < NUM_CMDS; i++) begin
            r_bank[i] <= '0;
            r_val[i]  <= '0;
         end
      end else if (w_load) begin
         r_len <= len_bytes;
         for (int i = 0; i < NUM_CMDS; i++) begin
            r_pair_ok[i] <= ((bank[i] >> BANK_BITS) == 32'd0) && ((val[i] >> VAL_BITS) == 32'd0);
            r_bank[i]    <= bank[i][7:0];
            r_val[i]     <= val[i][15:0];
         end
      end
   end

   assign busy          = r_busy;
   assign resp_valid    = r_resp_valid;
   assign resp          = r_resp;
   assign cmds_sent     = r_cmds;
   assign aso_cmd_valid = r_valid;
   assign aso_cmd_data  = r_data;

endmodule

// File: tb/tb_bank_cmd_multi.sv
// Directed self-checking bench for bank_cmd_multi (default parameters).
module tb_bank_cmd_multi;
   import task_icd_pkg::*;

   localparam int unsigned HB = HEADER_BYTES;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        task_valid;
   logic [31:0] len_bytes;
   logic [31:0] bank [4];
   logic [31:0] val  [4];
   logic        busy, resp_valid, aso_cmd_ready, aso_cmd_valid;
   logic [31:0] resp, aso_cmd_data;
   logic [4:0]  cmds_sent;

   always #5 clk = ~clk;

   bank_cmd_multi #(
      .NUM_CMDS(4), .BANK_BITS(4), .VAL_BITS(8), .CMD_ID(4'b0000), .MAX_TIMEOUT(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .task_valid(task_valid), .len_bytes(len_bytes),
      .bank(bank), .val(val), .busy(busy), .resp_valid(resp_valid), .resp(resp),
      .cmds_sent(cmds_sent), .aso_cmd_ready(aso_cmd_ready),
      .aso_cmd_valid(aso_cmd_valid), .aso_cmd_data(aso_cmd_data)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] q[$];
   int          vcnt = 0;
   int          resp_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (aso_cmd_valid) begin
            vcnt <= vcnt + 1;
            if (aso_cmd_ready) q.push_back(aso_cmd_data);
         end
         if (resp_valid) resp_cnt <= resp_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] par(input logic [31:0] w);
      logic [31:0] r;
      r = w;
`ifdef BANK_CMD_PARITY_EN
      r[27] = ~^w;
`endif
      return r;
   endfunction

   task automatic set_pair(input int i, input logic [31:0] b, input logic [31:0] v);
      bank[i] = b;
      val[i]  = v;
   endtask

   task automatic launch(input logic [31:0] l);
      @(posedge clk); #1;
      len_bytes  = l;
      task_valid = 1'b1;
      @(posedge clk); #1;
      task_valid = 1'b0;
   endtask

   task automatic wait_resp(input int max, output int lat, output logic [31:0] r);
      bit got;
      got = 0;
      lat = 0;
      r   = '0;
      while (lat < max && !got) begin
         @(negedge clk);
         lat++;
         if (resp_valid) begin
            got = 1;
            r   = resp;
         end
      end
      if (!got) chk("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic bad_len(input string tag, input logic [31:0] l);
      int lat, v0;
      logic [31:0] r;
      v0 = vcnt;
      launch(l);
      wait_resp(20, lat, r);
      chk({tag, "_resp"}, r, HEADER_INVALID);
      chk({tag, "_nostream"}, vcnt, v0);
   endtask

   initial begin
      int          lat, q0, v0, rc;
      logic [31:0] r;
      rst_n = 1'b0; task_valid = 1'b0; len_bytes = '0; aso_cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_pair(i, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", aso_cmd_valid, 0);
      chk("rst_resp", resp, 0);
      chk("rst_rv", resp_valid, 0);
      chk("rst_cmds", cmds_sent, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // three good pairs, back-to-back stream
      set_pair(0, 1, 32'h10); set_pair(1, 2, 32'h20); set_pair(2, 15, 32'hFF);
      q0 = q.size();
      launch(HB + 24);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!aso_cmd_valid && lat < 40);
      chk("t1_first_lat", lat, 6);
      wait_resp(20, lat, r);
      chk("t1_b2b_lat", lat, 3);
      chk("t1_resp", r, TASK_VALID);
      chk("t1_cmds", cmds_sent, 3);
      chk("t1_vdrop", aso_cmd_valid, 0);
      chk("t1_nwords", q.size() - q0, 3);
      if (q.size() - q0 == 3) begin
         chk("t1_w0", q[q0],   par(32'h0000_1001));
         chk("t1_w1", q[q0+1], par(32'h0000_2002));
         chk("t1_w2", q[q0+2], par(32'h0000_FF0F));
      end
      @(negedge clk);
      chk("t1_rv_pulse", resp_valid, 0);
      chk("t1_resp_hold", resp, TASK_VALID);
      chk("t1_idle", busy, 0);

      bad_len("len_mod8", HB + 12);
      bad_len("len_big", HB + 40);
      bad_len("len_zero", 0);

      // illegal bank inside limit
      set_pair(0, 3, 32'h44); set_pair(1, 16, 32'h01);
      v0 = vcnt;
      launch(HB + 16);
      wait_resp(20, lat, r);
      chk("pl_bank_resp", r, PAYLOAD_INVALID);
      chk("pl_bank_nostream", vcnt, v0);

      // illegal value (one past max) inside limit
      set_pair(0, 1, 32'h100);
      v0 = vcnt;
      launch(HB + 8);
      wait_resp(20, lat, r);
      chk("pl_val_resp", r, PAYLOAD_INVALID);
      chk("pl_val_nostream", vcnt, v0);

      // illegal bank beyond limit is never inspected
      set_pair(0, 3, 32'h44); set_pair(1, 1, 32'h02); set_pair(2, 16, 32'h01);
      q0 = q.size();
      launch(HB + 16);
      wait_resp(30, lat, r);
      chk("beyond_resp", r, TASK_VALID);
      chk("beyond_cmds", cmds_sent, 2);
      chk("beyond_nwords", q.size() - q0, 2);
      if (q.size() - q0 == 2) begin
         chk("beyond_w0", q[q0],   par(32'h0000_4403));
         chk("beyond_w1", q[q0+1], par(32'h0000_0201));
      end

      // full NUM_CMDS task
      set_pair(0, 0, 0); set_pair(1, 8, 32'h80); set_pair(2, 4, 32'h01); set_pair(3, 15, 32'h7F);
      q0 = q.size();
      launch(HB + 32);
      wait_resp(40, lat, r);
      chk("max_resp", r, TASK_VALID);
      chk("max_cmds", cmds_sent, 4);
      chk("max_nwords", q.size() - q0, 4);
      if (q.size() - q0 == 4) begin
         chk("max_w0", q[q0],   par(32'h0000_0000));
         chk("max_w1", q[q0+1], par(32'h0000_8008));
         chk("max_w2", q[q0+2], par(32'h0000_0104));
         chk("max_w3", q[q0+3], par(32'h0000_7F0F));
      end

      // stall after first handshake -> timeout
      set_pair(0, 5, 32'h55); set_pair(1, 6, 32'h66);
      q0 = q.size();
      launch(HB + 16);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!(aso_cmd_valid && aso_cmd_ready) && lat < 40);
      @(posedge clk); #1 aso_cmd_ready = 1'b0;
      wait_resp(1100, lat, r);
      chk("tmo_lat_ok", (lat == 1001 || lat == 1002), 1);
      chk("tmo_resp", r, EXE_ERROR);
      chk("tmo_cmds", cmds_sent, 1);
      chk("tmo_vdrop", aso_cmd_valid, 0);
      chk("tmo_nwords", q.size() - q0, 1);
      if (q.size() - q0 == 1) chk("tmo_w0", q[q0], par(32'h0000_5505));
      @(posedge clk); #1 aso_cmd_ready = 1'b1;

      // task_valid while busy is ignored
      set_pair(0, 7, 32'h77);
      q0 = q.size();
      rc = resp_cnt;
      launch(HB + 8);
      @(negedge clk);
      chk("ign_busy", busy, 1);
      @(posedge clk); #1 len_bytes = 0; task_valid = 1'b1;
      @(posedge clk); #1 task_valid = 1'b0;
      wait_resp(20, lat, r);
      chk("ign_resp", r, TASK_VALID);
      repeat (10) @(negedge clk);
      chk("ign_one_resp", resp_cnt - rc, 1);
      chk("ign_nwords", q.size() - q0, 1);
      if (q.size() - q0 == 1) chk("ign_w0", q[q0], par(32'h0000_7707));

      // reset during SRC
      set_pair(0, 1, 32'h11); set_pair(1, 2, 32'h22); set_pair(2, 3, 32'h33);
      aso_cmd_ready = 1'b0;
      launch(HB + 24);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!aso_cmd_valid && lat < 40);
      chk("rs_in_src", aso_cmd_valid, 1);
      @(posedge clk); #1 rst_n = 1'b0;
      #2;
      chk("rs_busy", busy, 0);
      chk("rs_valid", aso_cmd_valid, 0);
      chk("rs_data", aso_cmd_data, 0);
      chk("rs_rv", resp_valid, 0);
      chk("rs_resp", resp, 0);
      chk("rs_cmds", cmds_sent, 0);
      rc = resp_cnt;
      @(posedge clk); #1 rst_n = 1'b1; aso_cmd_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("rs_noresp", resp_cnt, rc);
      chk("rs_idle", busy, 0);
      chk("rs_novalid", aso_cmd_valid, 0);

`ifdef BANK_CMD_PARITY_EN
      for (int i = 0; i < q.size(); i++) chk("par_odd", $countones(q[i]) % 2, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
